dspm_req_splitter: RTL and testbench

DSPM_REQ_SPLITTER -- requirements
Module: dspm_req_splitter

---
 rtl/std_cache_pkg.sv | 40 ++++
 rtl/dspm_req_splitter.sv | 153 +++++++++++++++
 tb/tb_dspm_req_splitter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : std_cache_pkg
// Description : Shared data-cache port types and constants used by the core
//               load/store path, the SPM request splitter and the SPM
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package std_cache_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;
  localparam int unsigned DCACHE_DATA_WIDTH  = 64;
  localparam int unsigned DCACHE_BE_WIDTH    = DCACHE_DATA_WIDTH / 8;

  // Read data returned for an access that cannot be served (bad way/tag).
  localparam logic [DCACHE_DATA_WIDTH-1:0] SPM_ERR_RDATA = 64'hCA11AB1E_BADCAB1E;

  // Request from a load/store unit: index and tag may arrive in separate cycles.
  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [DCACHE_DATA_WIDTH-1:0]  data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [DCACHE_BE_WIDTH-1:0]    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  // Response towards a load/store unit.
  typedef struct packed {
    logic                          data_gnt;
    logic                          data_rvalid;
    logic [DCACHE_DATA_WIDTH-1:0]  data_rdata;
  } dcache_req_o_t;

endpackage
`default_nettype wire

// File: rtl/dspm_req_splitter.sv
`default_nettype none
// ============================================================================
// Module      : dspm_req_splitter
// Description : Converts the two-phase (index, then tag) core load/store
//               protocol into a single-phase request for an SPM controller.
//               Writes pass straight through; reads are latched and replayed.
// Revision    : 1.0 - initial release
// ============================================================================
module dspm_req_splitter
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_WAYS         = 4,
  parameter bit          CHECK_TAG_RANGE = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  dcache_req_i_t core_req_i,
  output dcache_req_o_t core_req_o,
  output dcache_req_i_t spm_req_o,
  input  dcache_req_o_t spm_req_i
);

  localparam int unsigned WAY_BITS = $clog2(NR_WAYS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_TAG = 2'd1,
    ISSUE    = 2'd2,
    WAIT_RSP = 2'd3
  } state_e;

  state_e                        state_q, state_d;
  logic [DCACHE_INDEX_WIDTH-1:0] index_q, index_d;
  logic [DCACHE_TAG_WIDTH-1:0]   tag_q,   tag_d;
  logic [DCACHE_BE_WIDTH-1:0]    be_q,    be_d;
  logic [1:0]                    size_q,  size_d;
  logic                          killed_q, killed_d;

  dcache_req_o_t w_core_rsp;
  dcache_req_i_t w_spm_req;
  logic          w_tag_oor;
  logic          w_suppress;

  // Any tag bit above the way-select bits means the way does not exist.
  function automatic logic tag_out_of_range(input logic [DCACHE_TAG_WIDTH-1:0] tag);
    logic [DCACHE_TAG_WIDTH-1:0] hi;
    hi = tag >> WAY_BITS;
    return CHECK_TAG_RANGE && (hi != '0);
  endfunction

  assign w_tag_oor  = tag_out_of_range(core_req_i.address_tag);
  // A kill in the response cycle itself also hides the response.
  assign w_suppress = killed_q | core_req_i.kill_req;

  // State and latched-request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      index_q  <= '0;
      tag_q    <= '0;
      be_q     <= '0;
      size_q   <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      tag_q    <= tag_d;
      be_q     <= be_d;
      size_q   <= size_d;
      killed_q <= killed_d;
    end
  end

  // Next-state logic and port outputs.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    tag_d      = tag_q;
    be_d       = be_q;
    size_d     = size_q;
    killed_d   = killed_q;
    w_core_rsp = '0;
    w_spm_req  = '0;

    case (state_q)
      IDLE: begin
        killed_d = 1'b0;
        if (core_req_i.data_req) begin
          if (core_req_i.data_we) begin
            // Stores carry index and tag together, so forward them as-is.
            w_spm_req.data_req      = 1'b1;
            w_spm_req.data_we       = 1'b1;
            w_spm_req.address_index = core_req_i.address_index;
            w_spm_req.address_tag   = core_req_i.address_tag;
            w_spm_req.data_wdata    = core_req_i.data_wdata;
            w_spm_req.data_be       = core_req_i.data_be;
            w_spm_req.data_size     = core_req_i.data_size;
            w_core_rsp.data_gnt     = spm_req_i.data_gnt;
          end else begin
            w_core_rsp.data_gnt = 1'b1;
            index_d             = core_req_i.address_index;
            be_d                = core_req_i.data_be;
            size_d              = core_req_i.data_size;
            state_d             = WAIT_TAG;
          end
        end
      end

      WAIT_TAG: begin
        if (core_req_i.kill_req) begin
          state_d = IDLE;
        end else if (core_req_i.tag_valid) begin
          tag_d   = core_req_i.address_tag;
          state_d = w_tag_oor ? WAIT_RSP : ISSUE;
        end
      end

      ISSUE: begin
        w_spm_req.data_req      = 1'b1;
        w_spm_req.address_index = index_q;
        w_spm_req.address_tag   = tag_q;
        w_spm_req.data_be       = be_q;
        w_spm_req.data_size     = size_q;
        if (core_req_i.kill_req) begin
          killed_d = 1'b1;
        end
        if (spm_req_i.data_rvalid) begin
          w_core_rsp.data_rvalid = ~w_suppress;
          w_core_rsp.data_rdata  = w_suppress ? '0 : spm_req_i.data_rdata;
          killed_d               = 1'b0;
          state_d                = IDLE;
        end
      end

      WAIT_RSP: begin
        w_core_rsp.data_rvalid = ~w_suppress;
        w_core_rsp.data_rdata  = w_suppress ? '0 : SPM_ERR_RDATA;
        killed_d               = 1'b0;
        state_d                = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even for pass-through writes.
  assign core_req_o = rst_i ? '0 : w_core_rsp;
  assign spm_req_o  = rst_i ? '0 : w_spm_req;

endmodule
`default_nettype wire

// File: tb/tb_dspm_req_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dspm_req_splitter
// Description : Self-checking bench for dspm_req_splitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dspm_req_splitter;
  import std_cache_pkg::*;

  logic          clk;
  logic          rst;
  dcache_req_i_t core_in;
  dcache_req_o_t core_out;
  dcache_req_i_t spm_out;
  dcache_req_o_t spm_in;

  int n_tests = 0;
  int n_fail  = 0;
  int spm_cnt = 0;
  logic [63:0] exp_q[$];

  dspm_req_splitter #(.NR_WAYS(4), .CHECK_TAG_RANGE(1'b1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .core_req_i (core_in),
    .core_req_o (core_out),
    .spm_req_o  (spm_out),
    .spm_req_i  (spm_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every core rvalid must match the oldest expected read result.
  always @(negedge clk) begin
    logic [63:0] e;
    if (spm_out.data_req) spm_cnt++;
    if (core_out.data_rvalid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected: got rdata %h expected no rvalid", core_out.data_rdata);
      end else begin
        e = exp_q.pop_front();
        if (core_out.data_rdata !== e) begin
          n_fail++;
          $display("FAIL rvalid_data: got %h expected %h", core_out.data_rdata, e);
        end
      end
    end
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [11:0] idx;
    logic [43:0] tag;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [1:0]  size;
    logic        sgnt;
    logic        exp_gnt;
    logic        exp_sreq;
  } vec_t;

  vec_t vecs[6];

  task automatic start_read(input logic [11:0] idx);
    core_in               = '0;
    core_in.data_req      = 1'b1;
    core_in.address_index = idx;
    core_in.data_be       = 8'hFF;
    core_in.data_size     = 2'd3;
  endtask

  task automatic send_tag(input logic [43:0] tag, input logic kill);
    core_in             = '0;
    core_in.tag_valid   = 1'b1;
    core_in.address_tag = tag;
    core_in.kill_req    = kill;
  endtask

  initial begin
    int c0;
    vecs[0] = '{1'b0, 1'b0, 12'h000, 44'h0,           64'h0,                  8'h00, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 12'h123, 44'h3,           64'h11223344_55667788,  8'hFF, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 12'h456, 44'h1,           64'hA5A5A5A5_5A5A5A5A,  8'hF0, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 12'hFFF, 44'hFFFFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF,  8'h01, 2'd0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 12'h321, 44'h2,           64'h12345678_9ABCDEF0,  8'hFF, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 12'h010, 44'h10,          64'h0BADC0DE_0000FFFF,  8'h3C, 2'd1, 1'b1, 1'b1, 1'b1};

    rst     = 1'b1;
    core_in = '0;
    spm_in  = '0;
    tick();
    // Outputs must stay low in reset even with a pass-through write applied.
    core_in          = '0;
    core_in.data_req = 1'b1;
    core_in.data_we  = 1'b1;
    core_in.data_be  = 8'hFF;
    spm_in.data_gnt  = 1'b1;
    #2;
    chk("rst_core_out", 64'(core_out), 64'h0);
    chk("rst_spm_req",  64'(spm_out.data_req), 64'h0);
    chk("rst_spm_be",   64'(spm_out.data_be), 64'h0);
    tick();
    core_in = '0;
    spm_in  = '0;
    rst     = 1'b0;
    tick();

    // Combinational IDLE behaviour: writes and idle inputs.
    for (int i = 0; i < 6; i++) begin
      core_in               = '0;
      core_in.data_req      = vecs[i].req;
      core_in.data_we       = vecs[i].we;
      core_in.address_index = vecs[i].idx;
      core_in.address_tag   = vecs[i].tag;
      core_in.data_wdata    = vecs[i].wdata;
      core_in.data_be       = vecs[i].be;
      core_in.data_size     = vecs[i].size;
      spm_in                = '0;
      spm_in.data_gnt       = vecs[i].sgnt;
      #2;
      chk($sformatf("v%0d_gnt", i),   64'(core_out.data_gnt), 64'(vecs[i].exp_gnt));
      chk($sformatf("v%0d_sreq", i),  64'(spm_out.data_req),  64'(vecs[i].exp_sreq));
      chk($sformatf("v%0d_swe", i),   64'(spm_out.data_we),   64'(vecs[i].exp_sreq));
      chk($sformatf("v%0d_idx", i),   64'(spm_out.address_index), vecs[i].exp_sreq ? 64'(vecs[i].idx) : 64'h0);
      chk($sformatf("v%0d_tag", i),   64'(spm_out.address_tag),   vecs[i].exp_sreq ? 64'(vecs[i].tag) : 64'h0);
      chk($sformatf("v%0d_wdata", i), spm_out.data_wdata,         vecs[i].exp_sreq ? vecs[i].wdata : 64'h0);
      chk($sformatf("v%0d_be", i),    64'(spm_out.data_be),       vecs[i].exp_sreq ? 64'(vecs[i].be) : 64'h0);
      chk($sformatf("v%0d_size", i),  64'(spm_out.data_size),     vecs[i].exp_sreq ? 64'(vecs[i].size) : 64'h0);
      chk($sformatf("v%0d_kt", i),    64'({spm_out.kill_req, spm_out.tag_valid}), 64'h0);
      tick();
    end
    core_in = '0;
    spm_in  = '0;
    tick();

    // Basic read: index 0x040, tag 0x2, response two cycles after issue.
    c0 = spm_cnt;
    start_read(12'h040);
    #2;
    chk("rd_gnt", 64'(core_out.data_gnt), 64'h1);
    chk("rd_sreq_idle", 64'(spm_out.data_req), 64'h0);
    tick();
    send_tag(44'h2, 1'b0);
    #2;
    chk("rd_gnt_waittag", 64'(core_out.data_gnt), 64'h0);
    chk("rd_sreq_waittag", 64'(spm_out.data_req), 64'h0);
    tick();
    core_in = '0;
    core_in.data_req = 1'b1;
    #2;
    chk("rd_issue_req", 64'(spm_out.data_req), 64'h1);
    chk("rd_issue_we", 64'(spm_out.data_we), 64'h0);
    chk("rd_issue_idx", 64'(spm_out.address_index), 64'h040);
    chk("rd_issue_tag", 64'(spm_out.address_tag), 64'h2);
    chk("rd_issue_be", 64'(spm_out.data_be), 64'hFF);
    chk("rd_issue_size", 64'(spm_out.data_size), 64'h3);
    chk("rd_issue_gnt", 64'(core_out.data_gnt), 64'h0);
    tick();
    core_in = '0;
    #2;
    chk("rd_issue_hold", 64'(spm_out.data_req), 64'h1);
    tick();
    spm_in.data_rvalid = 1'b1;
    spm_in.data_rdata  = 64'h00000000_DEADBEEF;
    exp_q.push_back(64'h00000000_DEADBEEF);
    #2;
    chk("rd_rv_req", 64'(spm_out.data_req), 64'h1);
    chk("rd_rv_core", 64'(core_out.data_rvalid), 64'h1);
    tick();
    spm_in = '0;
    #2;
    chk("rd_req_drop", 64'(spm_out.data_req), 64'h0);
    chk("rd_req_cycles", 64'(spm_cnt - c0), 64'd3);

    // Kill in WAIT_TAG beats a simultaneous tag; next read granted at once.
    c0 = spm_cnt;
    start_read(12'h080);
    tick();
    send_tag(44'h1, 1'b1);
    #2;
    chk("kt_sreq", 64'(spm_out.data_req), 64'h0);
    tick();
    start_read(12'h084);
    #2;
    chk("kt_regnt", 64'(core_out.data_gnt), 64'h1);
    tick();
    core_in = '0;
    core_in.kill_req = 1'b1;
    tick();
    core_in = '0;
    #2;
    chk("kt_no_spm", 64'(spm_cnt - c0), 64'd0);

    // Kill during ISSUE: access completes but the core sees nothing.
    start_read(12'h0C0);
    tick();
    send_tag(44'h1, 1'b0);
    tick();
    core_in = '0;
    core_in.kill_req = 1'b1;
    #2;
    chk("ki_req", 64'(spm_out.data_req), 64'h1);
    tick();
    core_in = '0;
    spm_in.data_rvalid = 1'b1;
    spm_in.data_rdata  = 64'h55;
    #2;
    chk("ki_req_rv", 64'(spm_out.data_req), 64'h1);
    chk("ki_core_rv", 64'(core_out.data_rvalid), 64'h0);
    tick();
    spm_in = '0;
    start_read(12'h0C4);
    #2;
    chk("ki_idle_gnt", 64'(core_out.data_gnt), 64'h1);
    chk("ki_idle_req", 64'(spm_out.data_req), 64'h0);
    tick();
    core_in = '0;
    core_in.kill_req = 1'b1;
    tick();
    core_in = '0;

    // Out-of-range tags: error data one cycle after the tag, no SPM access.
    for (int t = 0; t < 2; t++) begin
      c0 = spm_cnt;
      start_read(12'h100);
      tick();
      send_tag((t == 0) ? 44'h10 : 44'h4, 1'b0);
      #2;
      chk("oor_req_tag", 64'(spm_out.data_req), 64'h0);
      tick();
      core_in = '0;
      exp_q.push_back(64'hCA11AB1E_BADCAB1E);
      #2;
      chk("oor_rv", 64'(core_out.data_rvalid), 64'h1);
      chk("oor_req_rsp", 64'(spm_out.data_req), 64'h0);
      tick();
      #2;
      chk("oor_rv_once", 64'(core_out.data_rvalid), 64'h0);
      chk("oor_no_spm", 64'(spm_cnt - c0), 64'd0);
    end

    // Highest legal way goes to the SPM.
    start_read(12'h104);
    tick();
    send_tag(44'h3, 1'b0);
    tick();
    core_in = '0;
    spm_in.data_rvalid = 1'b1;
    spm_in.data_rdata  = 64'h13579BDF_2468ACE0;
    exp_q.push_back(64'h13579BDF_2468ACE0);
    #2;
    chk("way3_req", 64'(spm_out.data_req), 64'h1);
    chk("way3_tag", 64'(spm_out.address_tag), 64'h3);
    tick();
    spm_in = '0;

    // Write with grant held off for three cycles.
    core_in               = '0;
    core_in.data_req      = 1'b1;
    core_in.data_we       = 1'b1;
    core_in.address_index = 12'h0AB;
    core_in.address_tag   = 44'h1;
    core_in.data_wdata    = 64'hCAFEF00D_12345678;
    core_in.data_be       = 8'h0F;
    core_in.data_size     = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("wr_wait_gnt", 64'(core_out.data_gnt), 64'h0);
      chk("wr_wait_be", 64'(spm_out.data_be), 64'h0F);
      tick();
    end
    spm_in.data_gnt = 1'b1;
    #2;
    chk("wr_gnt", 64'(core_out.data_gnt), 64'h1);
    chk("wr_wdata", spm_out.data_wdata, 64'hCAFEF00D_12345678);
    chk("wr_idx", 64'(spm_out.address_index), 64'h0AB);
    tick();
    core_in = '0;
    spm_in  = '0;

    // Reset in ISSUE abandons the read; a fresh read then works.
    start_read(12'h040);
    tick();
    send_tag(44'h2, 1'b0);
    tick();
    core_in = '0;
    #2;
    chk("rs_issue", 64'(spm_out.data_req), 64'h1);
    rst = 1'b1;
    #1;
    chk("rs_spm_zero", 64'(spm_out.data_req), 64'h0);
    chk("rs_core_zero", 64'(core_out), 64'h0);
    tick();
    spm_in.data_rvalid = 1'b1;
    spm_in.data_rdata  = 64'h77;
    tick();
    rst = 1'b0;
    #2;
    chk("rs_no_rv", 64'(core_out.data_rvalid), 64'h0);
    chk("rs_no_req", 64'(spm_out.data_req), 64'h0);
    tick();
    tick();
    spm_in = '0;
    start_read(12'h200);
    #2;
    chk("rs_fresh_gnt", 64'(core_out.data_gnt), 64'h1);
    tick();
    send_tag(44'h0, 1'b0);
    tick();
    core_in = '0;
    spm_in.data_rvalid = 1'b1;
    spm_in.data_rdata  = 64'h00000000_0BADF00D;
    exp_q.push_back(64'h00000000_0BADF00D);
    #2;
    chk("rs_fresh_rv", 64'(core_out.data_rvalid), 64'h1);
    tick();
    spm_in = '0;
    tick();
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
